// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-store write side (loader) and fetch side.
// The byte-lane helper fixes the big-endian layout both sides must agree on.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int MEM_BYTES_DEF  = 512;

    // Byte lane of a 32-bit word that belongs at byte offset 'phase':
    // offset 0 holds bits [31:24], offset 3 holds bits [7:0].
    function automatic logic [1:0] be_lane(input logic [1:0] phase);
        return 2'd3 - phase;
    endfunction

endpackage

// File: rtl/imem_loader_word_byte_serializer.sv
// Holds one captured instruction word and presents it one byte per phase, MSB first.
// The phase counter wraps naturally after the fourth byte.
module imem_loader_word_byte_serializer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        advance,
    output logic [1:0]  phase,
    output logic [7:0]  bdata
);

    logic [31:0] sreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg  <= '0;
            phase <= '0;
        end else if (load) begin
            sreg  <= word;
            phase <= '0;
        end else if (advance) begin
            phase <= phase + 2'd1;
        end
    end

    assign bdata = sreg[{be_lane(phase), 3'b000} +: 8];

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into the byte-wide instruction store,
// four big-endian byte writes per word, after range-checking the request.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] num_words,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_word,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam logic [33:0] MEM_LIM    = 34'(MEM_BYTES);
    localparam logic [1:0]  LAST_PHASE = 2'(BYTES_PER_WORD - 1);

    state_t           state;
    logic [31:0]      cur_addr;
    logic [CNT_W-1:0] words_left;
    logic [1:0]       phase;
    logic [7:0]       ser_byte;
    logic [33:0]      req_end;
    logic             req_ok;
    logic             accept;

    // One past the last byte touched, kept wide so a huge base cannot wrap into range.
    assign req_end = {2'b00, base_addr} + 34'({num_words, 2'b00});
    assign req_ok  = (base_addr[1:0] == 2'b00) && (req_end <= MEM_LIM);
    assign accept  = (state == ACCEPT) && in_valid && in_ready;

    imem_loader_word_byte_serializer u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .word    (in_word),
        .advance (state == WRITE),
        .phase   (phase),
        .bdata   (ser_byte)
    );

    assign mem_addr  = cur_addr + {30'd0, phase};
    assign mem_wdata = ser_byte;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_addr   <= '0;
            words_left <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!req_ok) begin
                            error <= 1'b1;
                        end else if (num_words == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            cur_addr   <= base_addr;
                            words_left <= num_words;
                            state      <= ACCEPT;
                            in_ready   <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                end
                ACCEPT: begin
                    if (in_valid && in_ready) begin
                        state    <= WRITE;
                        in_ready <= 1'b0;
                        mem_we   <= 1'b1;
                    end
                end
                WRITE: begin
                    if (phase == LAST_PHASE) begin
                        mem_we     <= 1'b0;
                        cur_addr   <= cur_addr + 32'(BYTES_PER_WORD);
                        words_left <= words_left - CNT_W'(1);
                        if (words_left == CNT_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= ACCEPT;
                            in_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised load sequences checked cycle by cycle against a queue-based byte-write model,
// plus directed pins for latency, boundaries, backpressure and reset mid-load.
module tb_imem_loader;

    localparam int MEMB = 512;
    localparam int M_IDLE = 0, M_ACC = 1, M_WR = 2, M_DN = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [7:0]  num_words = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy, done, error;

    always #5 clk = ~clk;

    imem_loader #(.MEM_BYTES(MEMB), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_words(num_words), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error)
    );

    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic [7:0] store   [MEMB];
    logic [7:0] ref_mem [MEMB];

    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
    wr_t wq[$];
    int mode = M_IDLE, mleft = 0;
    logic [31:0] maddr = '0;
    logic e_ready = 0, e_we = 0, e_busy = 0, e_done = 0, e_err = 0;
    logic [31:0] e_addr = '0;
    logic [7:0]  e_data = '0;
    bit chk_en = 0;
    logic [31:0] feed[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fetch(input int a);
        return {store[a], store[a+1], store[a+2], store[a+3]};
    endfunction

    // Abstract model: a load is a list of byte writes, one per cycle, each word preceded by a handshake.
    task automatic model_step();
        longint last;
        cyc++;
        if (mode == M_WR && wq.size() > 0) ref_mem[wq[0].a[8:0]] = wq[0].d;
        if (!rst_n) begin
            mode = M_IDLE; wq.delete();
            {e_ready, e_we, e_busy, e_done, e_err} = '0;
        end else begin
            e_done = 0; e_err = 0;
            case (mode)
                M_WR: begin
                    void'(wq.pop_front());
                    if (wq.size() > 0) begin
                        e_addr = wq[0].a; e_data = wq[0].d;
                    end else begin
                        e_we = 0;
                        if (mleft == 0) begin mode = M_DN; e_done = 1; e_busy = 0; end
                        else begin mode = M_ACC; e_ready = 1; end
                    end
                end
                M_ACC: begin
                    if (in_valid) begin
                        for (int b = 0; b < 4; b++)
                            wq.push_back('{a: maddr + 32'(b), d: in_word[31-8*b -: 8]});
                        maddr = maddr + 32'd4; mleft--;
                        mode = M_WR; e_ready = 0; e_we = 1;
                        e_addr = wq[0].a; e_data = wq[0].d;
                    end
                end
                M_DN: mode = M_IDLE;
                default: begin
                    if (start) begin
                        last = longint'(base_addr) + 4 * longint'(num_words);
                        if (base_addr % 4 != 0 || last > MEMB) e_err = 1;
                        else if (num_words == 0) begin mode = M_DN; e_done = 1; end
                        else begin
                            maddr = base_addr; mleft = int'(num_words);
                            mode = M_ACC; e_ready = 1; e_busy = 1;
                        end
                    end
                end
            endcase
        end
        chk_en = 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("ctrl{rdy,we,busy,done,err}", {59'd0, in_ready, mem_we, busy, done, error},
                  {59'd0, e_ready, e_we, e_busy, e_done, e_err});
            if (e_we) begin
                check("mem_addr", 64'(mem_addr), 64'(e_addr));
                check("mem_wdata", 64'(mem_wdata), 64'(e_data));
            end
            if (mem_we) begin
                check("addr_in_range", 64'(mem_addr < MEMB), 64'd1);
                if (mem_addr < MEMB) store[mem_addr[8:0]] = mem_wdata;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_load(input logic [31:0] base, input int num, input int vpct,
                            input int hold, input bit noise, output int lat);
        int idx, guard, h, t0;
        bit acc;
        idx = 0; guard = 0; h = hold; lat = -1;
        start = 1; base_addr = base; num_words = 8'(num);
        tick();
        start = 0; t0 = cyc;
        while (guard < 2000) begin
            if (done) begin lat = cyc - t0; break; end
            if (error) break;
            if (h > 0) begin in_valid = 0; h--; end
            else in_valid = ($urandom_range(0, 99) < vpct);
            in_word = (idx < feed.size()) ? feed[idx] : $urandom;
            if (noise) begin
                start = ($urandom_range(0, 5) == 0);
                base_addr = $urandom; num_words = 8'($urandom);
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) begin idx++; h = hold; end
            guard++;
        end
        if (guard >= 2000) begin
            n_cmp++; n_bad++;
            $display("FAIL load_timeout: got no done after %0d cycles expected done", guard);
        end
        start = 0; in_valid = 0;
    endtask

    initial begin
        int lat, diffs;
        for (int i = 0; i < MEMB; i++) begin store[i] = 8'h55; ref_mem[i] = 8'h55; end

        rst_n = 0; tick(); tick(); rst_n = 1;
        check("reset_outputs", {21'd0, in_ready, mem_we, busy, done, error, mem_addr, mem_wdata}, 64'd0);

        // Normal two-word load; done is high during the 11th cycle after the start edge.
        feed = '{32'h2272F004, 32'hFAA23BDA};
        run_load(32'd0, 2, 100, 0, 0, lat);
        check("t1_done_latency", 64'(lat), 64'd10);
        check("t1_fetch0", 64'(fetch(0)), 64'h2272F004);
        check("t1_fetch4", 64'(fetch(4)), 64'hFAA23BDA);
        check("t1_byte0", 64'(store[0]), 64'h22);
        tick();

        // Backpressure: three idle cycles in ACCEPT, then the word.
        start = 1; base_addr = 32'd16; num_words = 8'd1; tick(); start = 0;
        for (int i = 0; i < 3; i++) begin
            check("t2_hold_rdy_we", {62'd0, in_ready, mem_we}, 64'b10);
            tick();
        end
        in_valid = 1; in_word = 32'h13579BDF; tick(); in_valid = 0;
        check("t2_first_write", {23'd0, mem_we, mem_addr, mem_wdata}, {23'd0, 1'b1, 32'd16, 8'h13});
        repeat (4) tick();
        check("t2_done", 64'(done), 64'd1);
        tick();

        // Rejected requests: misaligned, and crossing the end of the store.
        start = 1; base_addr = 32'd2; num_words = 8'd1; tick(); start = 0;
        check("t3_misaligned_err", {61'd0, error, busy, mem_we}, 64'b100);
        tick();
        check("t3_err_one_cycle", 64'(error), 64'd0);
        start = 1; base_addr = 32'd510; num_words = 8'd1; tick(); start = 0;
        check("t3_510_err", {61'd0, error, busy, mem_we}, 64'b100);
        tick();
        start = 1; base_addr = 32'd504; num_words = 8'd3; tick(); start = 0;
        check("t3_504x3_err", 64'(error), 64'd1);
        tick();
        feed = '{32'hDEADBEEF};
        run_load(32'd508, 1, 100, 0, 0, lat);
        check("t3_508_fetch", 64'(fetch(508)), 64'hDEADBEEF);
        tick();
        feed = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
        run_load(32'd500, 3, 100, 0, 0, lat);
        check("t3_500x3_fetch", 64'(fetch(508)), 64'h090A0B0C);
        tick();

        // Zero-length load.
        run_load(32'd32, 0, 100, 0, 0, lat);
        check("t4_zero_latency", 64'(lat), 64'd0);
        tick();

        // Reset during phase 2 of the first word.
        start = 1; base_addr = 32'd64; num_words = 8'd2; tick(); start = 0;
        in_valid = 1; in_word = 32'hABCDEF12; tick(); in_valid = 0;
        tick(); tick();
        rst_n = 0; tick(); rst_n = 1;
        check("t5_reset_outputs", {60'd0, in_ready, mem_we, busy, done}, 64'd0);
        check("t5_bytes_written", {40'd0, store[64], store[65], store[66]}, 64'hABCDEF);
        check("t5_byte3_untouched", 64'(store[67]), 64'h55);
        tick();

        // Start pulses and input churn during a load are ignored.
        feed = '{32'hCAFEF00D, 32'h8BADF00D, 32'h0D15EA5E};
        run_load(32'd80, 3, 100, 0, 1, lat);
        check("t5_noise_fetch", {fetch(84), fetch(88)}, {32'h8BADF00D, 32'h0D15EA5E});
        check("t5_noise_latency", 64'(lat), 64'd15);
        tick();

        // Randomised loads with random backpressure, holds and noise.
        for (int it = 0; it < 40; it++) begin
            logic [31:0] b;
            b = 32'($urandom_range(0, 130) * 4);
            if ($urandom_range(0, 7) == 0) b = b + 32'($urandom_range(1, 3));
            feed.delete();
            for (int w = 0; w < 8; w++) feed.push_back($urandom);
            run_load(b, $urandom_range(0, 6), 60, $urandom_range(0, 2), bit'($urandom_range(0, 1)), lat);
            tick();
            if ($urandom_range(0, 3) == 0) tick();
        end

        diffs = 0;
        for (int i = 0; i < MEMB; i++) if (store[i] !== ref_mem[i]) diffs++;
        check("mem_image_diff_bytes", 64'(diffs), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
